// File: rtl/dti_pack.sv
// Shared DTI CONDIS definitions: field positions, message types, entry states.
package dti_pack;

  localparam int unsigned MSG_TYPE_LSB    = 0;
  localparam int unsigned MSG_TYPE_MSB    = 3;
  localparam int unsigned STATE_BIT       = 4;
  localparam int unsigned TOK_LSB         = 8;
  localparam int unsigned TOK_MSB         = 15;
  localparam int unsigned MAX_TOK_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    CONNECTED    = 2'd1,
    TRANSACTION  = 2'd2,
    DISCONNECTED = 2'd3
  } entry_state_t;

  // TBU -> TCU message types
  typedef enum logic [3:0] {
    DTI_TBU_CONDIS_REQ = 4'h0,
    DTI_TBU_TRANS_REQ  = 4'h2
  } s_msg_type_t;

  // TCU -> TBU message types
  typedef enum logic [3:0] {
    DTI_TBU_CONDIS_ACK = 4'h0,
    DTI_TBU_TRANS_RESP = 4'h2
  } m_msg_type_t;

  typedef struct packed {
    logic [7:0] tok;
    logic [2:0] rsvd;
    logic       state;
    logic [3:0] msg_type;
  } condis_fields_t;

endpackage

// File: rtl/dti_condis_mgr_if.sv
// CONDIS request ingress (per TBU) and shared ack egress stream.
interface dti_condis_mgr_if #(
  parameter int unsigned TBU_NUM       = 2,
  parameter int unsigned TBU_NUM_WIDTH = 6,
  parameter int unsigned DATA_WIDTH    = 80
);
  logic [TBU_NUM-1:0]            s_req_valid;
  logic [TBU_NUM*DATA_WIDTH-1:0] s_req_data;
  logic [TBU_NUM-1:0]            s_req_ready;
  logic                          m_ack_valid;
  logic [DATA_WIDTH-1:0]         m_ack_data;
  logic [TBU_NUM_WIDTH-1:0]      m_ack_dest;
  logic                          m_ack_ready;

  modport slave (
    input  s_req_valid, s_req_data, m_ack_ready,
    output s_req_ready, m_ack_valid, m_ack_data, m_ack_dest
  );

  modport master (
    output s_req_valid, s_req_data, m_ack_ready,
    input  s_req_ready, m_ack_valid, m_ack_data, m_ack_dest
  );
endinterface

// File: rtl/dti_rr_arb.sv
// N-way round-robin arbiter; pointer moves to winner+1 on an enabled grant.
module dti_rr_arb #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req_i,
  input  logic          adv_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);
  logic [IW-1:0] ptr_q;
  logic          found;
  int unsigned   j;

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(ptr_q) + k) % N;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

  // Pointer advances past the winner only when the grant is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (adv_i && found) begin
      ptr_q <= (32'(idx_o) == N - 1) ? '0 : idx_o + 1'b1;
    end
  end
endmodule

// File: rtl/dti_condis_mgr.sv
// Per-TBU DTI connection manager: arbitrates CONDIS requests, tracks tokens.
module dti_condis_mgr
  import dti_pack::*;
#(
  parameter int unsigned TBU_NUM       = 2,
  parameter int unsigned TBU_NUM_WIDTH = 6,
  parameter int unsigned DATA_WIDTH    = 80,
  parameter int unsigned TOK_WIDTH     = 8,
  parameter int unsigned MAX_TOK       = MAX_TOK_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dti_condis_mgr_if.slave        condis,
  input  logic [TBU_NUM-1:0]     trans_issue,
  input  logic [TBU_NUM-1:0]     trans_done,
  output logic [2*TBU_NUM-1:0]   tbu_state,
  output logic [TBU_NUM-1:0]     err_pulse
);
  localparam int unsigned IDX_W = (TBU_NUM > 1) ? $clog2(TBU_NUM) : 1;
  localparam int unsigned FLD_W = $bits(condis_fields_t);

  logic [TBU_NUM-1:0]   eligible, gnt, ack_send, req_state;
  logic [TOK_WIDTH-1:0] ack_tok [TBU_NUM];
  logic [IDX_W-1:0]     win_idx;
  logic                 can_accept, new_ack;
  logic [DATA_WIDTH-1:0] ack_beat;

  logic                     ack_valid_q;
  logic [DATA_WIDTH-1:0]    ack_data_q;
  logic [TBU_NUM_WIDTH-1:0] ack_dest_q;

  assign can_accept = !ack_valid_q || condis.m_ack_ready;

  dti_rr_arb #(.N(TBU_NUM), .IW(IDX_W)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (eligible),
    .adv_i (can_accept),
    .gnt_o (gnt),
    .idx_o (win_idx)
  );

  assign condis.s_req_ready = can_accept ? gnt : '0;

  for (genvar i = 0; i < TBU_NUM; i++) begin : g_tbu
    condis_fields_t       f;
    entry_state_t         st_q, st_d;
    logic [TOK_WIDTH-1:0] cnt_q, cnt_d, gr_q, gr_d, treq, capped;
    logic                 err_q, err_d, is_req, accept, live;
    logic                 unused_bits;

    assign f      = condis.s_req_data[i*DATA_WIDTH +: FLD_W];
    assign unused_bits = ^{f.rsvd, condis.s_req_data[i*DATA_WIDTH+FLD_W +: DATA_WIDTH-FLD_W]};
    assign is_req = (f.msg_type == DTI_TBU_CONDIS_REQ);
    assign accept = condis.s_req_ready[i];
    assign treq   = TOK_WIDTH'(f.tok);
    assign capped = (treq > TOK_WIDTH'(MAX_TOK)) ? TOK_WIDTH'(MAX_TOK) : treq;

    // A disconnect is held back while translations are outstanding.
    assign eligible[i]  = condis.s_req_valid[i] &&
                          !(is_req && !f.state && st_q == TRANSACTION);
    assign ack_send[i]  = is_req;
    assign req_state[i] = f.state;
    assign ack_tok[i]   = (f.state && st_q == IDLE) ? capped : '0;

    // Next state: counter first (pre-accept state), then request handling.
    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      gr_d  = gr_q;
      err_d = 1'b0;
      live  = (st_q == CONNECTED) || (st_q == TRANSACTION);
      if (!(trans_issue[i] && trans_done[i] && live && cnt_q != '0)) begin
        if (trans_issue[i]) begin
          if (live && cnt_q != gr_q) cnt_d = cnt_d + 1'b1;
          else                       err_d = 1'b1;
        end
        if (trans_done[i]) begin
          if (cnt_q != '0) cnt_d = cnt_d - 1'b1;
          else             err_d = 1'b1;
        end
      end
      if (st_q == CONNECTED && cnt_d != '0)   st_d = TRANSACTION;
      if (st_q == TRANSACTION && cnt_d == '0) st_d = CONNECTED;
      if (st_q == DISCONNECTED) begin
        st_d = IDLE;
        gr_d = '0;
      end
      if (accept) begin
        if (!is_req) begin
          err_d = 1'b1;
        end else if (f.state) begin
          if (st_q == IDLE) begin
            st_d = CONNECTED;
            gr_d = capped;
          end else begin
            err_d = 1'b1;
          end
        end else if (st_q == CONNECTED) begin
          st_d = DISCONNECTED;
        end else begin
          err_d = 1'b1;
        end
      end
    end

    // Per-TBU state, outstanding count, granted tokens and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q  <= IDLE;
        cnt_q <= '0;
        gr_q  <= '0;
        err_q <= 1'b0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
        gr_q  <= gr_d;
        err_q <= err_d;
      end
    end

    assign tbu_state[2*i +: 2] = st_q;
    assign err_pulse[i]        = err_q;
  end

  assign new_ack = (|condis.s_req_ready) && ack_send[win_idx];

  // Ack beat for the current winner.
  always_comb begin
    ack_beat = '0;
    ack_beat[MSG_TYPE_MSB:MSG_TYPE_LSB] = DTI_TBU_CONDIS_ACK;
    ack_beat[STATE_BIT]                 = req_state[win_idx];
    ack_beat[TOK_MSB:TOK_LSB]           = (TOK_MSB-TOK_LSB+1)'(ack_tok[win_idx]);
  end

  // Single-entry ack register; refills in the same cycle it drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_valid_q <= 1'b0;
      ack_data_q  <= '0;
      ack_dest_q  <= '0;
    end else if (can_accept) begin
      ack_valid_q <= new_ack;
      if (new_ack) begin
        ack_data_q <= ack_beat;
        ack_dest_q <= TBU_NUM_WIDTH'(win_idx);
      end
    end
  end

  assign condis.m_ack_valid = ack_valid_q;
  assign condis.m_ack_data  = ack_data_q;
  assign condis.m_ack_dest  = ack_dest_q;
endmodule

// File: tb/tb_dti_condis_mgr.sv
// Directed bench for dti_condis_mgr with hand-computed expectations.
module tb_dti_condis_mgr;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] trans_issue, trans_done;
  logic [3:0] tbu_state;
  logic [1:0] err_pulse;
  int         checks = 0;
  int         errors = 0;
  int         beats  = 0;
  int         b0;

  dti_condis_mgr_if #(.TBU_NUM(2), .TBU_NUM_WIDTH(6), .DATA_WIDTH(80)) bus ();

  dti_condis_mgr #(
    .TBU_NUM(2), .TBU_NUM_WIDTH(6), .DATA_WIDTH(80), .TOK_WIDTH(8), .MAX_TOK(16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .condis      (bus.slave),
    .trans_issue (trans_issue),
    .trans_done  (trans_done),
    .tbu_state   (tbu_state),
    .err_pulse   (err_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rst_n && bus.m_ack_valid && bus.m_ack_ready) beats++;

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [79:0] beat(input logic [3:0] mt, input logic st, input logic [7:0] tok);
    beat        = '0;
    beat[3:0]   = mt;
    beat[4]     = st;
    beat[15:8]  = tok;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int i, input logic [79:0] b);
    bus.s_req_valid[i] = 1'b1;
    if (i == 0) bus.s_req_data[79:0]   = b;
    else        bus.s_req_data[159:80] = b;
  endtask

  task automatic drop(input int i);
    bus.s_req_valid[i] = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_vld"},   bus.m_ack_valid, 0);
    chk({tag, "_data"},  bus.m_ack_data,  0);
    chk({tag, "_dest"},  bus.m_ack_dest,  0);
    chk({tag, "_rdy"},   bus.s_req_ready, 0);
    chk({tag, "_state"}, tbu_state,       0);
    chk({tag, "_err"},   err_pulse,       0);
  endtask

  initial begin
    rst_n = 1'b0;
    trans_issue = '0;
    trans_done  = '0;
    bus.s_req_valid = '0;
    bus.s_req_data  = '0;
    bus.m_ack_ready = 1'b1;
    #12;
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick;

    // Simultaneous connects, ack stalled for three cycles, grant capping.
    b0 = beats;
    bus.m_ack_ready = 1'b0;
    req(0, beat(4'h0, 1'b1, 8'd2));
    req(1, beat(4'h0, 1'b1, 8'd40));
    #1 chk("rr_first_rdy", bus.s_req_ready, 2'b01);
    tick; drop(0); #1;
    chk("ack0_vld",  bus.m_ack_valid, 1);
    chk("ack0_data", bus.m_ack_data,  80'h0210);
    chk("ack0_dest", bus.m_ack_dest,  0);
    chk("tbu0_conn", tbu_state[1:0],  2'd1);
    chk("stall_rdy", bus.s_req_ready, 0);
    repeat (2) begin
      tick;
      chk("hold_data", bus.m_ack_data, 80'h0210);
      chk("hold_rdy",  bus.s_req_ready, 0);
    end
    bus.m_ack_ready = 1'b1;
    #1 chk("rr_second_rdy", bus.s_req_ready, 2'b10);
    tick; drop(1); #1;
    chk("ack1_data", bus.m_ack_data, 80'h1010);
    chk("ack1_dest", bus.m_ack_dest, 1);
    tick;
    chk("ack_drained", bus.m_ack_valid, 0);
    chk("beat_count",  beats - b0, 2);
    chk("both_conn",   tbu_state, 4'b0101);

    // Token accounting on TBU0 (grant 2).
    trans_issue = 2'b01;
    tick;
    chk("trans_state", tbu_state[1:0], 2'd2);
    chk("issue1_err",  err_pulse, 0);
    tick;
    chk("issue2_err",  err_pulse, 0);
    tick;
    trans_issue = 2'b00;
    chk("issue3_err",  err_pulse, 2'b01);
    tick;
    chk("err_one_cyc", err_pulse, 0);
    trans_issue = 2'b01;
    trans_done  = 2'b01;
    tick;
    trans_issue = 2'b00;
    trans_done  = 2'b00;
    chk("simul_err",   err_pulse, 0);
    chk("simul_state", tbu_state[1:0], 2'd2);

    // Disconnect held while outstanding, released once drained.
    req(0, beat(4'h0, 1'b0, 8'd0));
    #1 chk("disc_held", bus.s_req_ready, 0);
    trans_done = 2'b01;
    tick;
    chk("disc_held2",  bus.s_req_ready, 0);
    chk("done1_state", tbu_state[1:0], 2'd2);
    tick;
    trans_done = 2'b00;
    chk("drained_state", tbu_state[1:0], 2'd1);
    chk("disc_rdy",      bus.s_req_ready, 2'b01);
    tick; drop(0); #1;
    chk("disc_ack_vld",  bus.m_ack_valid, 1);
    chk("disc_ack_data", bus.m_ack_data,  80'h0000);
    chk("disc_state",    tbu_state[1:0],  2'd3);
    tick;
    chk("idle_state",    tbu_state[1:0],  2'd0);
    chk("idle_ack",      bus.m_ack_valid, 0);

    // Protocol errors: reconnect, unknown type, disconnect while idle.
    req(1, beat(4'h0, 1'b1, 8'd5));
    tick; drop(1); #1;
    chk("reconn_data",  bus.m_ack_data, 80'h0010);
    chk("reconn_dest",  bus.m_ack_dest, 1);
    chk("reconn_err",   err_pulse, 2'b10);
    chk("reconn_state", tbu_state[3:2], 2'd1);
    tick;
    chk("reconn_err_clr", err_pulse, 0);
    req(1, beat(4'h5, 1'b1, 8'd3));
    #1 chk("unk_rdy", bus.s_req_ready, 2'b10);
    tick; drop(1); #1;
    chk("unk_noack", bus.m_ack_valid, 0);
    chk("unk_err",   err_pulse, 2'b10);
    req(0, beat(4'h0, 1'b0, 8'd0));
    tick; drop(0); #1;
    chk("idle_disc_vld",   bus.m_ack_valid, 1);
    chk("idle_disc_data",  bus.m_ack_data, 80'h0000);
    chk("idle_disc_err",   err_pulse, 2'b01);
    chk("idle_disc_state", tbu_state[1:0], 2'd0);
    tick;

    // Asynchronous reset with a pending ack and three outstanding.
    bus.m_ack_ready = 1'b0;
    req(0, beat(4'h0, 1'b1, 8'd8));
    tick; drop(0); #1;
    trans_issue = 2'b01;
    repeat (3) tick;
    trans_issue = 2'b00;
    chk("pre_rst_vld",   bus.m_ack_valid, 1);
    chk("pre_rst_state", tbu_state, 4'b0110);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midrst");
    #1 rst_n = 1'b1;
    bus.m_ack_ready = 1'b1;
    tick;
    req(0, beat(4'h0, 1'b1, 8'd3));
    tick; drop(0); #1;
    chk("post_rst_data",  bus.m_ack_data, 80'h0310);
    chk("post_rst_dest",  bus.m_ack_dest, 0);
    chk("post_rst_state", tbu_state, 4'b0001);
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dti_condis_mgr.md
Name: dti_condis_mgr

Overview:
Per-TBU DTI connection manager on the TCU side of the DTI NoC, generalised to TBU_NUM channels.
- Arbitrates DTI_TBU_CONDIS_REQ messages from all TBU ingress channels.
- Runs one entry_state_t FSM per TBU and grants translation tokens.
- Tracks outstanding translations per TBU and holds a disconnect until that TBU is drained.
- Returns DTI_TBU_CONDIS_ACK on a single shared egress stream.

Parameters:
TBU_NUM, 2, number of TBU channels (1..64)
TBU_NUM_WIDTH, 6, width of the ack destination index
DATA_WIDTH, 80, message beat width (CUSTOM_DATA_WIDTH)
TOK_WIDTH, 8, width of the token request and grant fields
MAX_TOK, 16, cap on granted translation tokens per TBU

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_req_valid  in  TBU_NUM  per-TBU request beat valid
s_req_data  in  TBU_NUM*DATA_WIDTH  per-TBU request beat; TBU i occupies slice [i*DATA_WIDTH +: DATA_WIDTH]
s_req_ready  out  TBU_NUM  per-TBU request accept
m_ack_valid  out  1  ack beat valid
m_ack_data  out  DATA_WIDTH  ack beat
m_ack_dest  out  TBU_NUM_WIDTH  destination TBU index
m_ack_ready  in  1  downstream accept
trans_issue  in  TBU_NUM  one-cycle pulse: TBU i issued a translation
trans_done  in  TBU_NUM  one-cycle pulse: translation for TBU i completed
tbu_state  out  2*TBU_NUM  per-TBU entry_state_t
err_pulse  out  TBU_NUM  one-cycle protocol-error flag per TBU

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all FSMs IDLE, outstanding counters 0, granted tokens 0, round-robin pointer 0. m_ack_valid, s_req_ready, err_pulse and tbu_state are all 0. m_ack_data and m_ack_dest are 0.
- Request fields: [3:0] msg_type, [4] state (1 = connect, 0 = disconnect), [15:8] tok_req. Any other msg_type is dropped: accepted, no ack sent, err_pulse raised.
- Ack fields: [3:0] = DTI_TBU_CONDIS_ACK, [4] = echoed state, [15:8] = tok_grant. All other bits are 0.
- Eligibility: TBU i is eligible when s_req_valid[i] is high and it is not holding a disconnect. A disconnect is held while state is TRANSACTION.
- Arbitration:
  - Round-robin among eligible TBUs, starting from the pointer; the pointer moves to winner+1 after each grant.
  - At most one request is accepted per cycle, and only when the ack register is empty or m_ack_ready is high.
  - s_req_ready is combinational and one-hot or zero.
- Latency: a request accepted in cycle N produces m_ack_valid in cycle N+1. The ack holds until m_ack_ready is high; full throughput is 1 ack per cycle.
- FSM per TBU:
  - IDLE + connect: tok_grant = min(tok_req, MAX_TOK), stored; state becomes CONNECTED on accept. tok_req = 0 grants 0 and still connects.
  - CONNECTED + trans_issue: outstanding count increments; state becomes TRANSACTION.
  - TRANSACTION: when the outstanding count reaches 0, state becomes CONNECTED in the same cycle as the count update.
  - CONNECTED + disconnect: ack with state=0; state becomes DISCONNECTED, then IDLE on the next cycle, and the stored grant is cleared.
  - Disconnect received in TRANSACTION: stalled (ready low) until the TBU returns to CONNECTED, then handled as above.
  - Connect received in CONNECTED, TRANSACTION or DISCONNECTED: accepted, acked with state=1 and tok_grant=0, err_pulse raised, state unchanged.
  - Disconnect received in IDLE: acked with state=0, err_pulse raised, state stays IDLE.
- Outstanding counter (width TOK_WIDTH):
  - Simultaneous issue and done: count unchanged.
  - Issue when count == grant, or while in IDLE/DISCONNECTED: ignored, err_pulse raised.
  - Done at count 0: ignored, err_pulse raised; the counter never wraps.
- A request accept and a trans_issue in the same cycle on the same TBU: issue is evaluated against the pre-accept state.
- Reset asserted mid-operation clears everything immediately. A pending ack is lost; an upstream that expects it must re-request.

Decomposition:
- Into dti_pack:
  - CONDIS field bit-position constants (MSG_TYPE_LSB/MSB, STATE_BIT, TOK_LSB/MSB).
  - MAX_TOK default.
  - entry_state_t, m_msg_type_t and s_msg_type_t, all reused.
  - A condis_fields_t packed struct.
- Sub-module: dti_rr_arb (parametrised N-way round-robin arbiter). Inputs: req vector and advance enable. Outputs: one-hot grant and index.
- Per-TBU FSM and counter are generated in the top module.

Test Plan:
- TBU0 connect, tok_req=4 -> ack in the next cycle: data[4]=1, data[15:8]=4, dest=0; tbu_state[1:0]=CONNECTED. Then tok_req=40 on TBU1 -> grant 16.
- TBU0 and TBU1 both send connect in the same cycle, m_ack_ready held low 3 cycles -> TBU0 acked first, TBU1 acked the cycle after ready rises; no beat lost or duplicated.
- TBU0 connected with grant 2: issue twice -> TRANSACTION, count 2; third issue -> err_pulse[0]. Simultaneous issue and done -> count stays 2.
- TBU0 in TRANSACTION sends disconnect -> s_req_ready[0] stays 0. Two done pulses -> CONNECTED, then the disconnect is accepted; ack state=0, then DISCONNECTED for 1 cycle, then IDLE.
- Connect while already CONNECTED -> ack with tok_grant=0, err_pulse for one cycle, state unchanged. Unknown msg_type 4'h5 -> no ack, err_pulse.
- rst_n asserted while an ack is pending and count = 3 -> all outputs 0 asynchronously. After release, a fresh connect is acked normally.
